// File: rtl/sram_word_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_word_bridge
// Purpose  : Bridges a 32-bit word request port to an 8-bit asynchronous
//            SRAM. Each enabled byte lane becomes one external cycle
//            (SETUP, WAIT_CYC x STROBE, HOLD), lanes in ascending order.
//            A single-cycle ack_o pulse marks completion.
// Ports    : clk_i/rst_ni        clock, async active-low reset
//            req_i/we_i/be_i     request, direction, byte enables
//            addr_i/wdata_i      word address (bits [1:0] ignored), wdata
//            ready_o/ack_o       idle indication, completion pulse
//            rdata_o             read word, held until next read ack
//            sram_*              registered SRAM pins; data bus split into
//                                dq_o / dq_oe_o / dq_i for the top-level pad
// Revision : 1.0  initial release
// ============================================================================
module sram_word_bridge #(
   parameter int EXT_AW   = 20,
   parameter int WAIT_CYC = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [EXT_AW-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic              ready_o,
   output logic              ack_o,
   output logic [31:0]       rdata_o,
   output logic [EXT_AW-1:0] sram_addr_o,
   output logic              sram_ce_no,
   output logic              sram_we_no,
   output logic              sram_oe_no,
   output logic [7:0]        sram_dq_o,
   output logic              sram_dq_oe_o,
   input  logic [7:0]        sram_dq_i
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_STROBE = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_ACK    = 3'd4;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

   // Lowest set bit of a lane mask (0 when the mask is empty).
   function automatic logic [1:0] first_lane(input logic [3:0] m);
      first_lane = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) first_lane = 2'(i);
      end
   endfunction

   // Control state
   logic [2:0]        state_q, state_d;
   logic [1:0]        lane_q, lane_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q;
   logic [3:0]        be_q;
   logic [EXT_AW-3:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rbuf_q, rbuf_d;

   // Registered outputs
   logic              ready_q, ready_d;
   logic              ack_q, ack_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [EXT_AW-1:0] saddr_q, saddr_d;
   logic              ce_nq, ce_nd;
   logic              we_nq, we_nd;
   logic              oe_nq, oe_nd;
   logic [7:0]        dq_q, dq_d;
   logic              dq_oe_q, dq_oe_d;

   logic              w_accept;
   logic              w_active;
   logic [3:0]        w_done_mask;
   logic [3:0]        w_rem;
   logic              w_unused_addr;

   assign w_unused_addr = ^addr_i[1:0];

   // ready_q is only ever high while the FSM sits in IDLE.
   assign w_accept = req_i & ready_q;

   // Lanes at or below the current one are finished; the rest are pending.
   // For lane 3 the shift wraps to 0 and the subtraction yields 4'hF.
   assign w_done_mask = (4'd2 << lane_q) - 4'd1;
   assign w_rem       = be_q & ~w_done_mask;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      rbuf_d  = rbuf_q;
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               rbuf_d = '0;
               if (be_i != 4'd0) begin
                  state_d = ST_SETUP;
                  lane_d  = first_lane(be_i);
               end else begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
            cnt_d   = CNT_LOAD;
         end
         ST_STROBE: begin
            if (cnt_q == 4'd0) state_d = ST_HOLD;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_HOLD: begin
            // Pins lag the state by one cycle, so this edge closes the
            // last cycle in which oe_n is visibly low: sample here.
            if (!we_q) rbuf_d[{lane_q, 3'b000} +: 8] = sram_dq_i;
            if (w_rem != 4'd0) begin
               state_d = ST_SETUP;
               lane_d  = first_lane(w_rem);
            end else begin
               state_d = ST_ACK;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output image: every pin is a register loaded from the current state,
   // giving glitch-free strobes and one cycle of address/data setup and
   // hold around each strobe.
   // ------------------------------------------------------------------
   always_comb begin
      w_active = (state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                 (state_q == ST_HOLD);
      ce_nd    = ~w_active;
      we_nd    = ~((state_q == ST_STROBE) & we_q);
      oe_nd    = ~((state_q == ST_STROBE) & ~we_q);
      dq_oe_d  = w_active & we_q;
      saddr_d  = w_active ? {addr_q, lane_q} : saddr_q;
      dq_d     = (w_active & we_q) ? wdata_q[{lane_q, 3'b000} +: 8] : dq_q;
      ack_d    = (state_q == ST_ACK);
      rdata_d  = ((state_q == ST_ACK) && !we_q) ? rbuf_q : rdata_q;
      // Drops on the accepting edge, rises one cycle after the ack pulse.
      ready_d  = (state_q == ST_IDLE) & ~w_accept;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         lane_q  <= 2'd0;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         be_q    <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rbuf_q  <= 32'd0;
         ready_q <= 1'b1;
         ack_q   <= 1'b0;
         rdata_q <= 32'd0;
         saddr_q <= '0;
         ce_nq   <= 1'b1;
         we_nq   <= 1'b1;
         oe_nq   <= 1'b1;
         dq_q    <= 8'd0;
         dq_oe_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
         rbuf_q  <= rbuf_d;
         if (w_accept) begin
            we_q    <= we_i;
            be_q    <= be_i;
            addr_q  <= addr_i[EXT_AW-1:2];
            wdata_q <= wdata_i;
         end
         ready_q <= ready_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         saddr_q <= saddr_d;
         ce_nq   <= ce_nd;
         we_nq   <= we_nd;
         oe_nq   <= oe_nd;
         dq_q    <= dq_d;
         dq_oe_q <= dq_oe_d;
      end
   end

   assign ready_o      = ready_q;
   assign ack_o        = ack_q;
   assign rdata_o      = rdata_q;
   assign sram_addr_o  = saddr_q;
   assign sram_ce_no   = ce_nq;
   assign sram_we_no   = we_nq;
   assign sram_oe_no   = oe_nq;
   assign sram_dq_o    = dq_q;
   assign sram_dq_oe_o = dq_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_word_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_word_bridge
// Purpose  : Directed self-checking bench for sram_word_bridge. Two
//            instances (WAIT_CYC = 1 and WAIT_CYC = 3) each drive a small
//            behavioural async SRAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_word_bridge;

   localparam int AW = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          req1, req3;
   logic          we;
   logic [3:0]    be;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;

   logic          ready1, ack1, ce1, wen1, oen1, dqoe1;
   logic [31:0]   rdata1;
   logic [AW-1:0] saddr1;
   logic [7:0]    dq1, dqi1;
   logic          ready3, ack3, ce3, wen3, oen3, dqoe3;
   logic [31:0]   rdata3;
   logic [AW-1:0] saddr3;
   logic [7:0]    dq3, dqi3;

   int vectors    = 0;
   int miscompares = 0;

   sram_word_bridge #(.EXT_AW(AW), .WAIT_CYC(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .we_i(we), .be_i(be),
      .addr_i(addr), .wdata_i(wdata), .ready_o(ready1), .ack_o(ack1),
      .rdata_o(rdata1), .sram_addr_o(saddr1), .sram_ce_no(ce1),
      .sram_we_no(wen1), .sram_oe_no(oen1), .sram_dq_o(dq1),
      .sram_dq_oe_o(dqoe1), .sram_dq_i(dqi1));

   sram_word_bridge #(.EXT_AW(AW), .WAIT_CYC(3)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .we_i(we), .be_i(be),
      .addr_i(addr), .wdata_i(wdata), .ready_o(ready3), .ack_o(ack3),
      .rdata_o(rdata3), .sram_addr_o(saddr3), .sram_ce_no(ce3),
      .sram_we_no(wen3), .sram_oe_no(oen3), .sram_dq_o(dq3),
      .sram_dq_oe_o(dqoe3), .sram_dq_i(dqi3));

   // Async SRAM models: write on rising we_n while selected, read while oe_n low.
   logic [7:0] mem1 [0:4095];
   logic [7:0] mem3 [0:4095];
   assign dqi1 = (!ce1 && !oen1) ? mem1[saddr1[11:0]] : 8'hFF;
   assign dqi3 = (!ce3 && !oen3) ? mem3[saddr3[11:0]] : 8'hFF;
   always @(posedge wen1) if (rst_n && !ce1) mem1[saddr1[11:0]] = dq1;
   always @(posedge wen3) if (rst_n && !ce3) mem3[saddr3[11:0]] = dq3;

   // Instance selector for the shared request helper.
   bit            sel = 1'b0;
   logic          m_ready, m_ack, m_ce, m_wen, m_oen;
   logic [31:0]   m_rdata;
   logic [AW-1:0] m_saddr;
   assign m_ready = sel ? ready3 : ready1;
   assign m_ack   = sel ? ack3   : ack1;
   assign m_ce    = sel ? ce3    : ce1;
   assign m_wen   = sel ? wen3   : wen1;
   assign m_oen   = sel ? oen3   : oen1;
   assign m_rdata = sel ? rdata3 : rdata1;
   assign m_saddr = sel ? saddr3 : saddr1;

   // Issues one request and measures it. lat = edges from the accepting
   // edge to the start of the ack cycle (200 on timeout, -1 if never ready).
   task automatic run_req(input logic w, input logic [3:0] b,
                          input logic [AW-1:0] a, input logic [31:0] d,
                          input bit keep,
                          output int lat, output int wt, output int ce_cnt,
                          output int we_cnt, output int oe_cnt,
                          output int we_run_max, output int viol,
                          output logic [31:0] rd, output logic rdy_at_ack);
      int            run;
      logic          prev_wen;
      logic [AW-1:0] prev_addr;
      ce_cnt = 0; we_cnt = 0; oe_cnt = 0; we_run_max = 0; viol = 0;
      rd = 32'hx; rdy_at_ack = 1'bx; wt = 0; run = 0;
      @(negedge clk);
      we = w; be = b; addr = a; wdata = d;
      if (sel) req3 = 1'b1; else req1 = 1'b1;
      while (!m_ready && wt < 50) begin
         @(negedge clk);
         wt++;
      end
      if (!m_ready) begin
         lat = -1;
         req1 = 1'b0; req3 = 1'b0;
         return;
      end
      @(posedge clk);
      prev_wen  = m_wen;
      prev_addr = m_saddr;
      for (lat = 0; lat < 200; lat++) begin
         @(negedge clk);
         if (lat == 0 && !keep) begin req1 = 1'b0; req3 = 1'b0; end
         if (!m_ce) ce_cnt++;
         if (!m_oen) oe_cnt++;
         if (!m_wen) begin
            we_cnt++;
            run++;
            if (prev_wen && m_saddr != prev_addr) viol++;
         end else begin
            run = 0;
         end
         if (run > we_run_max) we_run_max = run;
         prev_wen  = m_wen;
         prev_addr = m_saddr;
         if (m_ack) begin
            rd = m_rdata;
            rdy_at_ack = m_ready;
            break;
         end
         @(posedge clk);
      end
   endtask

   int          lat, wt, cec, wec, oec, wrun, viol;
   logic [31:0] rd;
   logic        rdy;

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (ready1 !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", ready1); end
      vectors++; if (ack1 !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0", ack1); end
      vectors++; if (rdata1 !== 32'd0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0", rdata1); end
      vectors++; if ({ce1, wen1, oen1} !== 3'b111) begin miscompares++; $display("FAIL reset_strobes: got %b expected 111", {ce1, wen1, oen1}); end
      vectors++; if ({dqoe1, dq1} !== 9'd0) begin miscompares++; $display("FAIL reset_dq: got %h expected 0", {dqoe1, dq1}); end
      vectors++; if (saddr1 !== '0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", saddr1); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_write;
      sel = 1'b0;
      run_req(1'b1, 4'hF, 20'h00100, 32'hDEADBEEF, 1'b0, lat, wt, cec, wec, oec, wrun, viol, rd, rdy);
      vectors++; if (lat !== 13) begin miscompares++; $display("FAIL wr_latency: got %0d expected 13", lat); end
      vectors++; if (wec !== 4 || wrun !== 1) begin miscompares++; $display("FAIL wr_we_pulses: got %0d cycles run %0d expected 4 run 1", wec, wrun); end
      vectors++; if (cec !== 12) begin miscompares++; $display("FAIL wr_ce_cycles: got %0d expected 12", cec); end
      vectors++; if (viol !== 0) begin miscompares++; $display("FAIL wr_addr_setup: got %0d violations expected 0", viol); end
      vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL wr_ready_at_ack: got %b expected 0", rdy); end
      vectors++; if ({mem1[12'h103], mem1[12'h102], mem1[12'h101], mem1[12'h100]} !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL wr_mem: got %h expected deadbeef", {mem1[12'h103], mem1[12'h102], mem1[12'h101], mem1[12'h100]});
      end
   endtask

   task automatic test_full_read;
      sel = 1'b0;
      run_req(1'b0, 4'hF, 20'h00100, 32'h0, 1'b0, lat, wt, cec, wec, oec, wrun, viol, rd, rdy);
      vectors++; if (lat !== 13) begin miscompares++; $display("FAIL rd_latency: got %0d expected 13", lat); end
      vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
      vectors++; if (oec !== 4 || wec !== 0) begin miscompares++; $display("FAIL rd_strobes: got oe %0d we %0d expected oe 4 we 0", oec, wec); end
      // Held after the ack pulse ends.
      @(negedge clk);
      vectors++; if (rdata1 !== 32'hDEADBEEF || ack1 !== 1'b0) begin miscompares++; $display("FAIL rd_hold: got %h ack %b expected deadbeef ack 0", rdata1, ack1); end
   endtask

   task automatic test_sparse;
      sel = 1'b0;
      run_req(1'b1, 4'h5, 20'h00200, 32'h11223344, 1'b0, lat, wt, cec, wec, oec, wrun, viol, rd, rdy);
      vectors++; if (lat !== 7 || wec !== 2) begin miscompares++; $display("FAIL sparse_wr_timing: got lat %0d we %0d expected lat 7 we 2", lat, wec); end
      vectors++; if ({mem1[12'h203], mem1[12'h202], mem1[12'h201], mem1[12'h200]} !== 32'h59225B44) begin
         miscompares++;
         $display("FAIL sparse_wr_mem: got %h expected 59225b44", {mem1[12'h203], mem1[12'h202], mem1[12'h201], mem1[12'h200]});
      end
      // Low address bits are ignored: 0x203 reads the word at 0x200.
      run_req(1'b0, 4'hA, 20'h00203, 32'h0, 1'b0, lat, wt, cec, wec, oec, wrun, viol, rd, rdy);
      vectors++; if (rd !== 32'h59005B00) begin miscompares++; $display("FAIL sparse_rd_data: got %h expected 59005b00", rd); end
      vectors++; if (lat !== 7 || oec !== 2) begin miscompares++; $display("FAIL sparse_rd_timing: got lat %0d oe %0d expected lat 7 oe 2", lat, oec); end
   endtask

   task automatic test_reset_mid;
      int n;
      sel = 1'b0;
      @(negedge clk);
      we = 1'b1; be = 4'hF; addr = 20'h00040; wdata = 32'h12345678; req1 = 1'b1;
      n = 0;
      while (wen1 && n < 30) begin @(negedge clk); n++; end
      req1 = 1'b0;
      vectors++; if (wen1 !== 1'b0) begin miscompares++; $display("FAIL rstmid_strobe_seen: got we_n %b expected 0", wen1); end
      #2 rst_n = 1'b0;
      #1;
      vectors++; if ({ce1, wen1, oen1, dqoe1} !== 4'b1110) begin miscompares++; $display("FAIL rstmid_async: got %b expected 1110", {ce1, wen1, oen1, dqoe1}); end
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (20) begin @(negedge clk); if (ack1) n++; end
      vectors++; if (ready1 !== 1'b1 || n !== 0) begin miscompares++; $display("FAIL rstmid_after: got ready %b acks %0d expected ready 1 acks 0", ready1, n); end
   endtask

   task automatic test_zero_back_to_back;
      sel = 1'b0;
      run_req(1'b0, 4'h0, 20'h00100, 32'h0, 1'b0, lat, wt, cec, wec, oec, wrun, viol, rd, rdy);
      vectors++; if (lat !== 1 || cec !== 0) begin miscompares++; $display("FAIL zero_be: got lat %0d ce %0d expected lat 1 ce 0", lat, cec); end
      vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL zero_be_rdata: got %h expected 0", rd); end
      // First request keeps req_i high through its ack.
      run_req(1'b1, 4'h2, 20'h00300, 32'hAABBCCDD, 1'b1, lat, wt, cec, wec, oec, wrun, viol, rd, rdy);
      vectors++; if (lat !== 4 || rdy !== 1'b0) begin miscompares++; $display("FAIL b2b_first: got lat %0d ready %b expected lat 4 ready 0", lat, rdy); end
      run_req(1'b0, 4'h2, 20'h00300, 32'h0, 1'b0, lat, wt, cec, wec, oec, wrun, viol, rd, rdy);
      vectors++; if (wt !== 0 || lat !== 4) begin miscompares++; $display("FAIL b2b_second: got wait %0d lat %0d expected wait 0 lat 4", wt, lat); end
      vectors++; if (rd !== 32'h0000CC00) begin miscompares++; $display("FAIL b2b_rdata: got %h expected 0000cc00", rd); end
   endtask

   task automatic test_wait3;
      sel = 1'b1;
      run_req(1'b0, 4'h4, 20'h00300, 32'h0, 1'b0, lat, wt, cec, wec, oec, wrun, viol, rd, rdy);
      vectors++; if (lat !== 6) begin miscompares++; $display("FAIL w3_latency: got %0d expected 6", lat); end
      vectors++; if (oec !== 3 || cec !== 5) begin miscompares++; $display("FAIL w3_strobes: got oe %0d ce %0d expected oe 3 ce 5", oec, cec); end
      vectors++; if (rd !== 32'h00580000) begin miscompares++; $display("FAIL w3_rdata: got %h expected 00580000", rd); end
      sel = 1'b0;
   endtask

   initial begin
      req1 = 1'b0; req3 = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = 32'h0;
      rst_n = 1'b0;
      for (int i = 0; i < 4096; i++) begin
         mem1[i] = 8'(i) ^ 8'h5A;
         mem3[i] = 8'(i) ^ 8'h5A;
      end
      test_reset;
      test_full_write;
      test_full_read;
      test_sparse;
      test_reset_mid;
      test_zero_back_to_back;
      test_wait3;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
